// File: rtl/mfp_seven_segment_scanner.sv
// mfp_seven_segment_scanner: time-multiplexed hex display scanner with per-frame snapshot, blanking and leading-zero blanking.
// Optional MFP_SEVEN_SEG_BRIGHTNESS_EN adds a 4-bit PWM brightness input captured with the frame snapshot.
module mfp_seven_segment_scanner #(
    parameter int N_DIGITS       = 8,
    parameter int REFRESH_DIV    = 12500,
    parameter int BLANK_CYCLES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] hex_in,
    input  logic [N_DIGITS-1:0]   dot_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  lz_blank,
`ifdef MFP_SEVEN_SEG_BRIGHTNESS_EN
    input  logic [3:0]            brightness,
`endif
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   an_out,
    output logic                  frame_tick
);
    localparam int CW = $clog2(REFRESH_DIV) < 4 ? 4 : $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic SL = SEG_ACTIVE_LOW != 0;
    localparam logic AL = AN_ACTIVE_LOW != 0;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] snap_hex_q;
    logic [N_DIGITS-1:0]   snap_dot_q, snap_en_q, lz_off, an_q, an_d;
    logic                  snap_lz_q, ft_q, dp_q, dp_d, wrap, load, on, bright_ok;
    logic [6:0]            seg_q, seg_d, seg_hi;
    logic [3:0]            nib;
`ifdef MFP_SEVEN_SEG_BRIGHTNESS_EN
    logic [3:0]            snap_bri_q;
    assign bright_ok = 4'(cnt_q - CW'(BLANK_CYCLES)) <= snap_bri_q;
`else
    assign bright_ok = 1'b1;
`endif
    assign wrap  = cnt_q == CW'(REFRESH_DIV - 1);
    assign load  = cnt_q == '0 && idx_q == '0;
    assign cnt_d = wrap ? '0 : cnt_q + 1'b1;
    assign idx_d = wrap ? (idx_q == IW'(N_DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
    assign nib   = 4'(snap_hex_q >> {idx_q, 2'b00});
    // a digit is blanked only if it and every more significant digit is a plain zero
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_lz
        assign lz_off[g] = (g != 0) && snap_lz_q && ~|(snap_hex_q >> (4 * g)) && ~|(snap_dot_q >> g);
    end
    always_comb begin
        seg_hi = 7'h00;
        case (nib)
            4'h0: seg_hi = 7'h3F;
            4'h1: seg_hi = 7'h06;
            4'h2: seg_hi = 7'h5B;
            4'h3: seg_hi = 7'h4F;
            4'h4: seg_hi = 7'h66;
            4'h5: seg_hi = 7'h6D;
            4'h6: seg_hi = 7'h7D;
            4'h7: seg_hi = 7'h07;
            4'h8: seg_hi = 7'h7F;
            4'h9: seg_hi = 7'h6F;
            4'hA: seg_hi = 7'h77;
            4'hB: seg_hi = 7'h7C;
            4'hC: seg_hi = 7'h39;
            4'hD: seg_hi = 7'h5E;
            4'hE: seg_hi = 7'h79;
            4'hF: seg_hi = 7'h71;
            default: seg_hi = 7'h00;
        endcase
    end
    assign on    = cnt_q >= CW'(BLANK_CYCLES) && snap_en_q[idx_q] && !lz_off[idx_q] && bright_ok;
    assign an_d  = on ? {N_DIGITS{AL}} ^ (N_DIGITS'(1) << idx_q) : {N_DIGITS{AL}};
    assign seg_d = seg_hi ^ {7{SL}};
    assign dp_d  = snap_dot_q[idx_q] ^ SL;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            snap_hex_q <= '0;
            snap_dot_q <= '0;
            snap_en_q  <= '0;
            snap_lz_q  <= 1'b0;
`ifdef MFP_SEVEN_SEG_BRIGHTNESS_EN
            snap_bri_q <= '0;
`endif
            ft_q       <= 1'b0;
            an_q       <= {N_DIGITS{AL}};
            seg_q      <= {7{SL}};
            dp_q       <= SL;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            ft_q  <= load;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            if (load) begin
                snap_hex_q <= hex_in;
                snap_dot_q <= dot_in;
                snap_en_q  <= digit_en;
                snap_lz_q  <= lz_blank;
`ifdef MFP_SEVEN_SEG_BRIGHTNESS_EN
                snap_bri_q <= brightness;
`endif
            end
        end
    end
    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign frame_tick = ft_q;
endmodule
